// File: rtl/recursive_prop_pkg.sv
// Shared types for the recursive property monitor.
// Mode and channel-state encodings plus phase width helper.
package recursive_prop_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ALWAYS     = 2'd1,
    MODE_WEAK_UNTIL = 2'd2,
    MODE_PHASE      = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chan_st_t;

  function automatic int ph_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/recursive_prop_chan.sv
// One monitor channel: ALWAYS / WEAK_UNTIL / PHASE checker
// with sticky fail flag and saturating violation counter.
module recursive_prop_chan
  import recursive_prop_pkg::*;
#(
  parameter int NPHASE = 2,
  parameter int CNT_W  = 8,
  parameter int PW     = ph_width(NPHASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic [NPHASE-1:0] trig_i,
  input  logic [NPHASE-1:0] cond_p_i,
  input  logic              cond_q_i,
  input  logic              clr_i,
  output logic              armed_o,
  output logic [PW-1:0]     phase_o,
  output logic              pass_o,
  output logic              fail_pulse_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              fail_nxt_o
);

  mode_t      mode;
  mode_t      mode_q;
  chan_st_t   st_q;
  chan_st_t   st_d;
  logic [PW-1:0]    ph_d;
  logic             pass_d;
  logic             fpl_d;
  logic             fail_d;
  logic             armed_d;
  logic [CNT_W-1:0] cnt_d;
  logic             s0;
  logic             p0;
  logic             sph;
  logic             pph;

  always_comb begin
    mode   = mode_t'(mode_i);
    st_d   = st_q;
    ph_d   = phase_o;
    pass_d = 1'b0;
    fpl_d  = 1'b0;
    fail_d = fail_o;
    cnt_d  = fail_cnt_o;
    s0     = trig_i[0];
    p0     = cond_p_i[0];
    sph    = trig_i[phase_o];
    pph    = cond_p_i[phase_o];
    if (clr_i) begin
      st_d   = ST_IDLE;
      ph_d   = '0;
      fail_d = 1'b0;
      cnt_d  = '0;
    end else if (mode != mode_q) begin
      st_d = ST_IDLE;
      ph_d = '0;
    end else begin
      unique case (mode)
        MODE_OFF: begin
          st_d = ST_IDLE;
          ph_d = '0;
        end
        MODE_ALWAYS: begin
          if (st_q == ST_IDLE) begin
            if (s0) st_d = ST_ARMED;
          end else if (!p0) begin
            fpl_d = 1'b1;
            st_d  = ST_IDLE;
          end
        end
        MODE_WEAK_UNTIL: begin
          if (st_q == ST_IDLE) begin
            if (s0) st_d = ST_ARMED;
          end else if (cond_q_i) begin
            // a coincident trigger opens a fresh obligation
            pass_d = 1'b1;
            st_d   = s0 ? ST_ARMED : ST_IDLE;
          end else if (!p0) begin
            fpl_d = 1'b1;
            st_d  = ST_IDLE;
          end
        end
        MODE_PHASE: begin
          st_d = ST_IDLE;
          if (sph && pph) begin
            if (phase_o == PW'(NPHASE - 1)) ph_d = '0;
            else ph_d = phase_o + 1'b1;
          end else begin
            fpl_d = sph;
            ph_d  = '0;
          end
        end
      endcase
    end
    if (fpl_d) begin
      fail_d = 1'b1;
      if (fail_cnt_o != '1) cnt_d = fail_cnt_o + 1'b1;
    end
    armed_d = (st_d == ST_ARMED) || (ph_d != '0);
  end

  assign fail_nxt_o = fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_OFF;
      st_q         <= ST_IDLE;
      phase_o      <= '0;
      armed_o      <= 1'b0;
      pass_o       <= 1'b0;
      fail_pulse_o <= 1'b0;
      fail_o       <= 1'b0;
      fail_cnt_o   <= '0;
    end else begin
      mode_q       <= mode;
      st_q         <= st_d;
      phase_o      <= ph_d;
      armed_o      <= armed_d;
      pass_o       <= pass_d;
      fail_pulse_o <= fpl_d;
      fail_o       <= fail_d;
      fail_cnt_o   <= cnt_d;
    end
  end

endmodule

// File: rtl/recursive_prop_monitor.sv
// Multi-channel temporal property monitor: NCH independent
// channels plus a registered global fail summary.
module recursive_prop_monitor
  import recursive_prop_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NPHASE = 2,
  parameter int CNT_W  = 8,
  parameter int PW     = ph_width(NPHASE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*2-1:0]        mode_i,
  input  logic [NCH*NPHASE-1:0]   trig_i,
  input  logic [NCH*NPHASE-1:0]   cond_p_i,
  input  logic [NCH-1:0]          cond_q_i,
  input  logic [NCH-1:0]          clr_i,
  output logic [NCH-1:0]          armed_o,
  output logic [NCH*PW-1:0]       phase_o,
  output logic [NCH-1:0]          pass_o,
  output logic [NCH-1:0]          fail_pulse_o,
  output logic [NCH-1:0]          fail_o,
  output logic [NCH*CNT_W-1:0]    fail_cnt_o,
  output logic                    any_fail_o
);

  logic [NCH-1:0] fail_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    recursive_prop_chan #(
      .NPHASE (NPHASE),
      .CNT_W  (CNT_W),
      .PW     (PW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_i       (mode_i[c*2 +: 2]),
      .trig_i       (trig_i[c*NPHASE +: NPHASE]),
      .cond_p_i     (cond_p_i[c*NPHASE +: NPHASE]),
      .cond_q_i     (cond_q_i[c]),
      .clr_i        (clr_i[c]),
      .armed_o      (armed_o[c]),
      .phase_o      (phase_o[c*PW +: PW]),
      .pass_o       (pass_o[c]),
      .fail_pulse_o (fail_pulse_o[c]),
      .fail_o       (fail_o[c]),
      .fail_cnt_o   (fail_cnt_o[c*CNT_W +: CNT_W]),
      .fail_nxt_o   (fail_nxt[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_fail_o <= 1'b0;
    else        any_fail_o <= |fail_nxt;
  end

endmodule

// File: doc/recursive_prop_monitor.md
RECURSIVE_PROP_MONITOR -- requirements
Module: recursive_prop_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent monitor channels (1..32).
REQ-002 SHALL have parameter NPHASE, default 2, phases in the cyclic phase chain (2..8).
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-channel failure counter.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mode_i  input  NCH x 2  per-channel mode: 0 OFF, 1 ALWAYS, 2 WEAK_UNTIL, 3 PHASE.
REQ-007 SHALL have port trig_i  input  NCH x NPHASE  triggers: bit 0 is s in ALWAYS/WEAK_UNTIL, bit k is s of phase k in PHASE.
REQ-008 SHALL have port cond_p_i  input  NCH x NPHASE  conditions: bit 0 is p in ALWAYS/WEAK_UNTIL, bit k is the phase-k property in PHASE.
REQ-009 SHALL have port cond_q_i  input  NCH  release condition q (WEAK_UNTIL only).
REQ-010 SHALL have port clr_i  input  NCH  synchronous per-channel clear.
REQ-011 SHALL have port armed_o  output  NCH  obligation active.
REQ-012 SHALL have port phase_o  output  NCH x clog2(NPHASE)  current phase index.
REQ-013 SHALL have port pass_o  output  NCH  one-cycle pulse on WEAK_UNTIL discharge.
REQ-014 SHALL have port fail_pulse_o  output  NCH  one-cycle pulse per violation.
REQ-015 SHALL have port fail_o  output  NCH  sticky violation flag.
REQ-016 SHALL have port fail_cnt_o  output  NCH x CNT_W  saturating violation count.
REQ-017 SHALL have port any_fail_o  output  1  OR of fail_o.

Function
REQ-018 All outputs SHALL be registered; a sample at edge k SHALL produce its response in the cycle after edge k.
REQ-019 Each channel SHALL have states IDLE, ARMED, and phase index ph; unused trig/cond bits SHALL be ignored.
REQ-020 ALWAYS: in IDLE, s=1 SHALL move to ARMED; in ARMED, p=0 SHALL pulse fail and return to IDLE; p=1 stays ARMED; further s is absorbed.
REQ-021 WEAK_UNTIL: in IDLE, s=1 SHALL move to ARMED; in ARMED, q=1 SHALL take priority over p, pulse pass_o and go IDLE.
REQ-022 WEAK_UNTIL in ARMED: q=0 and p=0 SHALL pulse fail and go IDLE; q=0 and p=1 stays ARMED.
REQ-023 WEAK_UNTIL: q=1 with s=1 in the same ARMED sample SHALL pulse pass_o and remain ARMED, a new obligation.
REQ-024 The trigger sample itself SHALL NOT be checked in ALWAYS/WEAK_UNTIL; checking starts next sample (|=>).
REQ-025 PHASE: armed_o SHALL be 1 while ph!=0; each sample evaluates s[ph] and p[ph] in the same sample (|->).
REQ-026 PHASE: s[ph]=1,p[ph]=1 SHALL advance ph to (ph+1) mod NPHASE, wrapping from NPHASE-1 to 0.
REQ-027 PHASE: s[ph]=1,p[ph]=0 SHALL pulse fail and reset ph to 0; s[ph]=0 SHALL end the chain vacuously and reset ph to 0.
REQ-028 OFF and any mode_i change SHALL abort: state IDLE, ph=0, with no pass or fail pulse in that cycle.
REQ-029 A fail pulse SHALL set fail_o and increment fail_cnt_o, saturating at 2^CNT_W-1.
REQ-030 clr_i SHALL override all events that cycle: IDLE, ph=0, fail_o=0, fail_cnt_o=0, no pulses.
REQ-031 Channels SHALL be fully independent; any_fail_o SHALL be the registered OR of next-state fail_o.

Reset
REQ-032 rst_n=0 SHALL immediately force all channels IDLE, ph=0, and every output to 0 regardless of clk.
REQ-033 Reset mid-obligation SHALL drop the obligation; after release the first sample SHALL be evaluated from IDLE.

Structure
REQ-034 Package recursive_prop_pkg SHALL hold the mode enum (OFF/ALWAYS/WEAK_UNTIL/PHASE) and the channel state enum.
REQ-035 Sub-module recursive_prop_chan SHALL implement one channel; the top SHALL generate NCH instances plus any_fail_o.

Verification
REQ-036 ALWAYS: s=1 at edge 1, p=1 edges 2-5, p=0 edge 6 -> fail_pulse at edge 6 only, fail_o=1, fail_cnt=1, armed_o=0 after.
REQ-037 WEAK_UNTIL: s at edge 1, p=1 edges 2-3, q=1,p=0 edge 4 -> pass_o pulse after edge 4, no fail; repeat with q=0 -> fail.
REQ-038 PHASE, NPHASE=3: s/p for phases 0,1,2 high on edges 1-3 -> ph 1,2,0; s[1]=1,p[1]=0 at ph=1 -> fail, ph=0.
REQ-039 CNT_W=2: force 5 ALWAYS violations -> fail_cnt_o = 1,2,3,3,3; then clr_i=1 -> fail_o=0, fail_cnt_o=0.
REQ-040 Drop rst_n asynchronously mid-cycle while ARMED with fail_o=1 -> outputs 0 before next edge; after release IDLE.
REQ-041 NCH=4: violate channel 2 only and change mode on channel 0 while ARMED -> only fail_o[2]=1, channel 0 IDLE, no pulses.
